// File: rtl/clkdiv_tick_rx.sv
// rtl/clkdiv_tick_rx.sv - divided-clock edge detector with tick, period measurement and loss-of-clock flag
module clkdiv_tick_rx #(
  parameter logic [31:0] TIMEOUT = 32'd12000000,
  parameter int          CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clk_div_in,
  input  logic             en,
  output logic             tick,
  output logic [31:0]      period,
  output logic             period_valid,
  output logic             timeout,
  output logic [CNT_W-1:0] tick_count,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    LOST    = 2'd2
  } state_t;

  state_t      cur_state, nxt_state;
  logic        s1, s2, s3;
  logic        fill1, fill2, armed;
  logic        edge_det;
  logic [31:0] cnt, cnt_nxt, period_nxt;
  logic        pv_nxt, to_nxt;

  // armed only after s2 carries a genuine low sample, so a level already high at reset release is not an edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      s3    <= 1'b0;
      fill1 <= 1'b0;
      fill2 <= 1'b0;
      armed <= 1'b0;
    end else begin
      s1    <= clk_div_in;
      s2    <= s1;
      s3    <= s2;
      fill1 <= 1'b1;
      fill2 <= fill1;
      armed <= armed | (fill2 & ~s2);
    end
  end

  assign edge_det = s2 & ~s3 & armed;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick       <= 1'b0;
      tick_count <= '0;
    end else begin
      tick <= edge_det & en;
      if (edge_det && en)
        tick_count <= tick_count + CNT_W'(1);
    end
  end

  always_comb begin
    nxt_state  = cur_state;
    cnt_nxt    = cnt;
    period_nxt = period;
    pv_nxt     = 1'b0;
    to_nxt     = timeout;
    if (!en) begin
      nxt_state = IDLE;
      cnt_nxt   = 32'd0;
      to_nxt    = 1'b0;
    end else begin
      case (cur_state)
        IDLE: begin
          if (edge_det) begin
            nxt_state = MEASURE;
            cnt_nxt   = 32'd1;
          end else begin
            cnt_nxt = 32'd0;
          end
        end
        MEASURE: begin
          // an edge landing on the timeout cycle still counts as a valid interval
          if (edge_det) begin
            period_nxt = cnt;
            pv_nxt     = 1'b1;
            cnt_nxt    = 32'd1;
          end else if (cnt == TIMEOUT) begin
            nxt_state = LOST;
            to_nxt    = 1'b1;
          end else begin
            cnt_nxt = cnt + 32'd1;
          end
        end
        LOST: begin
          if (edge_det) begin
            nxt_state = MEASURE;
            cnt_nxt   = 32'd1;
            to_nxt    = 1'b0;
          end
        end
        default: nxt_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_state    <= IDLE;
      cnt          <= 32'd0;
      period       <= 32'd0;
      period_valid <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      cnt          <= cnt_nxt;
      period       <= period_nxt;
      period_valid <= pv_nxt;
      timeout      <= to_nxt;
    end
  end

  assign state = cur_state;

endmodule

// File: doc/clkdiv_tick_rx.md
CLKDIV_TICK_RX -- requirements
Module: clkdiv_tick_rx

Interface
REQ-001 Parameter TIMEOUT, default 32'd12000000, max clk cycles allowed between detected rising edges before loss is flagged.
REQ-002 Parameter CNT_W, default 16, width of tick_count.
REQ-003 clk  input  1  system clock; single clock domain for all logic.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 clk_div_in  input  1  slow toggling clock from the divider; asynchronous to clk.
REQ-006 en  input  1  measurement enable, synchronous to clk.
REQ-007 tick  output  1  one-cycle pulse per detected rising edge of clk_div_in.
REQ-008 period  output  32  clk cycles between the last two consecutive detected rising edges.
REQ-009 period_valid  output  1  one-cycle pulse when period updates.
REQ-010 timeout  output  1  sticky flag: no rising edge within TIMEOUT cycles.
REQ-011 tick_count  output  CNT_W  count of ticks issued, wraps modulo 2^CNT_W.
REQ-012 state  output  2  current FSM state: 0 IDLE, 1 MEASURE, 2 LOST.

Function
REQ-013 clk_div_in SHALL pass through a 2-flop synchronizer (s1, s2), then a history flop s3; edge = s2 & ~s3.
REQ-014 tick SHALL be registered: high for exactly one cycle, at the 3rd clk rising edge after clk_div_in is first sampled 1; never two consecutive cycles.
REQ-015 tick SHALL be suppressed while en=0; synchronizer and history flops SHALL run regardless of en.
REQ-016 tick_count SHALL increment by 1 in the cycle tick is asserted; wraps from all-ones to 0.
REQ-017 Internal counter cnt (32 bit) SHALL be set to 1 on each edge cycle and increment by 1 on every other cycle in MEASURE.
REQ-018 IDLE: cnt=0; on edge with en=1 -> MEASURE, cnt=1; no period_valid.
REQ-019 MEASURE: on edge -> period<=cnt, period_valid=1 next cycle, cnt<=1, stay MEASURE.
REQ-020 MEASURE: if cnt==TIMEOUT and no edge this cycle -> LOST, timeout<=1.
REQ-021 MEASURE: edge coincident with cnt==TIMEOUT SHALL win: period<=TIMEOUT, period_valid, no timeout.
REQ-022 LOST: cnt holds; on edge -> MEASURE, cnt<=1, timeout<=0, no period_valid (interval invalid).
REQ-023 en=0 in any state SHALL force IDLE next cycle, cnt<=0, timeout<=0; period and tick_count hold.
REQ-024 period SHALL hold its last value between updates.
REQ-025 Steady input from a 100 MHz divider with half-period 5000001 cycles SHALL yield period=10000002.

Reset
REQ-026 rst=1 SHALL immediately clear s1,s2,s3, cnt, period, tick_count to 0; tick, period_valid, timeout to 0; state to IDLE.
REQ-027 rst asserted mid-measurement SHALL discard the partial interval; first edge after release re-enters MEASURE with no period_valid.
REQ-028 No tick SHALL be generated from a clk_div_in already high at reset release (s3 reset 0 SHALL NOT produce a false edge: edge requires s3 observed 0 after a synchronized 0 level).

Verification
REQ-029 Reset release, en=1, clk_div_in square wave half-period 20 cycles -> tick every 40 cycles, first period_valid at 2nd edge with period=40, tick_count=N after N edges.
REQ-030 TIMEOUT=50, clk_div_in held low after one edge -> state LOST and timeout=1 exactly 50 cycles after edge; next edge -> MEASURE, timeout=0, no period_valid.
REQ-031 TIMEOUT=50, edges exactly 50 cycles apart -> period=50, period_valid, timeout stays 0.
REQ-032 en dropped for 10 cycles mid-MEASURE -> IDLE, no ticks during en=0; after re-enable, first edge gives no period_valid, second gives correct period.
REQ-033 CNT_W=4, 17 edges -> tick_count=1 after wrap.
REQ-034 rst pulsed with clk_div_in high, released high -> no tick until the next genuine low-to-high transition.
